// File: rtl/rule_infer.sv
// Infers the elementary-CA rule from consecutive ring states, one cell per cycle (N+1 cycles per pair).
// st_ready drops for the N-cycle scan; a beat held during the scan is taken once when the scan ends.
module rule_infer #(
    parameter int N  = 20,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [N-1:0]  st_data,
    input  logic          st_seq,
    output logic [7:0]    rul,
    output logic [7:0]    known,
    output logic          complete,
    output logic          conflict,
    output logic [2:0]    conflict_idx,
    output logic [PW-1:0] pairs,
    output logic          busy
);
    localparam int PSW = $clog2(N);
    localparam logic [PSW-1:0] LAST = PSW'(N - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_IDLE,
        S_SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    prev_q, prev_d;
    logic [N-1:0]    curr_q, curr_d;
    logic [PSW-1:0]  pos_q, pos_d;
    logic [7:0]      rul_q, rul_d;
    logic [7:0]      known_q, known_d;
    logic            conflict_q, conflict_d;
    logic [2:0]      cidx_q, cidx_d;
    logic [PW-1:0]   pairs_q, pairs_d;

    logic [PSW-1:0]  pos_nx, pos_pv;
    logic [2:0]      idx;
    logic            obs;
    logic            accept;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        curr_d     = curr_q;
        pos_d      = pos_q;
        rul_d      = rul_q;
        known_d    = known_q;
        conflict_d = conflict_q;
        cidx_d     = cidx_q;
        pairs_d    = pairs_q;

        // ring neighbours of the cell under scan
        pos_nx = (pos_q == LAST) ? '0 : pos_q + PSW'(1);
        pos_pv = (pos_q == '0) ? LAST : pos_q - PSW'(1);
        idx    = {prev_q[pos_nx], prev_q[pos_q], prev_q[pos_pv]};
        obs    = curr_q[pos_q];
        accept = st_valid && (state_q != S_SCAN);

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    prev_d  = st_data;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (st_seq) begin
                        prev_d = st_data;
                    end else begin
                        curr_d  = st_data;
                        pos_d   = '0;
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (!known_q[idx]) begin
                    known_d[idx] = 1'b1;
                    rul_d[idx]   = obs;
                end else if ((rul_q[idx] != obs) && !conflict_q) begin
                    conflict_d = 1'b1;
                    cidx_d     = idx;
                end
                if (pos_q == LAST) begin
                    prev_d  = curr_q;
                    state_d = S_IDLE;
                    if (pairs_q != '1) begin
                        pairs_d = pairs_q + PW'(1);
                    end
                end else begin
                    pos_d = pos_nx;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_EMPTY;
            prev_q     <= '0;
            curr_q     <= '0;
            pos_q      <= '0;
            rul_q      <= '0;
            known_q    <= '0;
            conflict_q <= 1'b0;
            cidx_q     <= '0;
            pairs_q    <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            curr_q     <= curr_d;
            pos_q      <= pos_d;
            rul_q      <= rul_d;
            known_q    <= known_d;
            conflict_q <= conflict_d;
            cidx_q     <= cidx_d;
            pairs_q    <= pairs_d;
        end
    end

    assign st_ready     = (state_q != S_SCAN);
    assign busy         = (state_q == S_SCAN);
    assign rul          = rul_q;
    assign known        = known_q;
    assign complete     = &known_q;
    assign conflict     = conflict_q;
    assign conflict_idx = cidx_q;
    assign pairs        = pairs_q;
endmodule

// File: tb/tb_rule_infer.sv
// Randomized and directed bench for rule_infer against a table-level reference model.
module tb_rule_infer;
    localparam int N = 20;

    logic         clk = 1'b0;
    logic         res;
    logic         st_valid;
    logic         st_seq;
    logic [N-1:0] st_data;
    logic         st_ready, complete, conflict, busy;
    logic [7:0]   rul, known;
    logic [2:0]   conflict_idx;
    logic [7:0]   pairs;
    logic         st_ready2, complete2, conflict2, busy2;
    logic [7:0]   rul2, known2;
    logic [2:0]   conflict_idx2;
    logic [1:0]   pairs2;

    rule_infer #(.N(N), .PW(8)) u_dut (
        .clk(clk), .res(res), .st_valid(st_valid), .st_ready(st_ready),
        .st_data(st_data), .st_seq(st_seq), .rul(rul), .known(known),
        .complete(complete), .conflict(conflict), .conflict_idx(conflict_idx),
        .pairs(pairs), .busy(busy)
    );

    rule_infer #(.N(N), .PW(2)) u_dut_sat (
        .clk(clk), .res(res), .st_valid(st_valid), .st_ready(st_ready2),
        .st_data(st_data), .st_seq(st_seq), .rul(rul2), .known(known2),
        .complete(complete2), .conflict(conflict2), .conflict_idx(conflict_idx2),
        .pairs(pairs2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: rule table as seen by an observer of whole states
    logic [N-1:0] m_prev;
    bit           m_has;
    logic [7:0]   m_rul, m_known;
    bit           m_conf;
    logic [2:0]   m_cidx;
    int           m_pairs;

    function automatic logic [2:0] nb(input logic [N-1:0] s, input int p);
        return {s[(p + 1) % N], s[p], s[(p + N - 1) % N]};
    endfunction

    function automatic logic [7:0] partial_known(input logic [7:0] b, input logic [N-1:0] pv, input int n);
        for (int p = 0; p < n; p++) b[nb(pv, p)] = 1'b1;
        return b;
    endfunction

    function automatic logic [N-1:0] ca_step(input logic [7:0] r, input logic [N-1:0] pv);
        logic [N-1:0] c;
        for (int p = 0; p < N; p++) c[p] = r[nb(pv, p)];
        return c;
    endfunction

    task automatic model_pair(input logic [N-1:0] pv, input logic [N-1:0] cu);
        logic [2:0] i;
        for (int p = 0; p < N; p++) begin
            i = nb(pv, p);
            if (!m_known[i]) begin
                m_known[i] = 1'b1;
                m_rul[i]   = cu[p];
            end else if (m_rul[i] != cu[p] && !m_conf) begin
                m_conf = 1'b1;
                m_cidx = i;
            end
        end
        m_pairs++;
    endtask

    task automatic model_clear();
        m_has = 0; m_rul = '0; m_known = '0; m_conf = 0; m_cidx = '0; m_pairs = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_known"}, 32'(known), 32'(m_known));
        check({tag, "_rul"}, 32'(rul), 32'(m_rul));
        check({tag, "_complete"}, 32'(complete), 32'(&m_known));
        check({tag, "_conflict"}, 32'(conflict), 32'(m_conf));
        check({tag, "_cidx"}, 32'(conflict_idx), 32'(m_cidx));
        check({tag, "_pairs"}, 32'(pairs), (m_pairs > 255) ? 32'd255 : 32'(m_pairs));
        check({tag, "_pairs_sat"}, 32'(pairs2), (m_pairs > 3) ? 32'd3 : 32'(m_pairs));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(st_ready), 32'd1);
    endtask

    task automatic do_reset();
        res = 1'b1; st_valid = 1'b0; st_seq = 1'b0; st_data = '0;
        step();
        res = 1'b0;
        model_clear();
        check_outputs("rst");
    endtask

    // offer one beat; if hold, keep st_valid up with nd for the following beat
    task automatic send(input logic [N-1:0] d, input logic s, input bit hold, input logic [N-1:0] nd);
        int w;
        int cnt;
        bit pair;
        logic [7:0] base;
        logic [N-1:0] pv;
        st_valid = 1'b1; st_data = d; st_seq = s;
        w = 0;
        while (!st_ready && w < 50) begin
            step();
            w++;
        end
        if (!st_ready) begin
            check("ready_timeout", 32'(st_ready), 32'd1);
            st_valid = 1'b0;
            return;
        end
        pair = m_has && !s;
        pv   = m_prev;
        base = m_known;
        step();
        if (hold) begin
            st_data = nd; st_seq = 1'b0;
        end else begin
            st_valid = 1'b0;
        end
        if (pair) begin
            cnt = 0;
            while (!st_ready && cnt < 40) begin
                check("scan_busy", 32'(busy), 32'd1);
                check("scan_known", 32'(known), 32'(partial_known(base, pv, cnt)));
                step();
                cnt++;
            end
            check("scan_len", 32'(cnt), 32'(N));
            model_pair(pv, d);
        end else begin
            check("noscan_ready", 32'(st_ready), 32'd1);
        end
        m_prev = d;
        m_has  = 1;
        check_outputs(pair ? "pair" : "load");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        logic [7:0]   r;
        logic [N-1:0] d;
        logic         s;
        res = 1'b1; st_valid = 1'b0; st_seq = 1'b0; st_data = '0;
        model_clear();
        step();
        do_reset();

        // single pair, directed values
        send(20'h00001, 1'b0, 0, '0);
        send(20'h80000, 1'b0, 0, '0);
        check("t1_known", 32'(known), 32'h17);
        check("t1_rul", 32'(rul & known), 32'h10);
        check("t1_pairs", 32'(pairs), 32'd1);

        // full rule recovery
        do_reset();
        send(20'h00003, 1'b0, 0, '0);
        send(20'h80002, 1'b0, 0, '0);
        send(20'h55555, 1'b1, 0, '0);
        send(20'hAAAAA, 1'b0, 0, '0);
        send(20'hFFFFF, 1'b1, 0, '0);
        send(20'hFFFFF, 1'b0, 0, '0);
        check("t2_rul", 32'(rul), 32'hB8);
        check("t2_complete", 32'(complete), 32'd1);
        check("t2_pairs", 32'(pairs), 32'd3);

        // conflict, then later contradictions keep the first index
        do_reset();
        send(20'h00000, 1'b0, 0, '0);
        send(20'h00001, 1'b0, 0, '0);
        check("t3_conflict", 32'(conflict), 32'd1);
        check("t3_rul0", 32'(rul[0]), 32'd1);
        send(20'h00000, 1'b0, 0, '0);
        send(20'h00001, 1'b1, 0, '0);
        send(20'h00001, 1'b0, 0, '0);
        check("t3_cidx_sticky", 32'(conflict_idx), 32'd0);

        // backpressure: beat held through the scan is consumed once
        do_reset();
        send(20'h12345, 1'b0, 0, '0);
        send(20'h0F0F0, 1'b0, 1, 20'h3C3C3);
        send(20'h3C3C3, 1'b0, 0, '0);
        repeat (5) step();
        check("t4_pairs", 32'(pairs), 32'd2);
        check("t4_ready", 32'(st_ready), 32'd1);

        // reset in the middle of a scan
        do_reset();
        send(20'hABCDE, 1'b0, 0, '0);
        st_valid = 1'b1; st_data = 20'h13579; st_seq = 1'b0;
        step();
        st_valid = 1'b0;
        repeat (10) step();
        check("t5_busy_before", 32'(busy), 32'd1);
        res = 1'b1;
        step();
        res = 1'b0;
        model_clear();
        check_outputs("t5_abort");
        send(20'h13579, 1'b0, 0, '0);
        check("t5_pairs", 32'(pairs), 32'd0);

        // pair-counter saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 6; i++) send(20'h00000, 1'b0, 0, '0);
        check("t6_pairs_sat", 32'(pairs2), 32'd3);
        check("t6_known", 32'(known2), 32'h01);
        check("t6_rul", 32'(rul2), 32'h00);

        // random streams generated by a random rule (consistent transitions)
        do_reset();
        r = 8'($urandom);
        for (int i = 0; i < 30; i++) begin
            s = ($urandom_range(0, 5) == 0);
            d = s ? N'($urandom) : ca_step(r, m_prev);
            send(d, s, 0, '0);
        end
        check("rand_rule_conflict", 32'(conflict), 32'd0);

        // random mix of rule steps and arbitrary states
        do_reset();
        r = 8'($urandom);
        for (int i = 0; i < 30; i++) begin
            s = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 1) == 0) ? ca_step(r, m_prev) : N'($urandom);
            send(d, s, 0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rule_infer.md
# rule_infer

Rule-identification engine for the elementary cellular-automaton datapath: the observer end of the automaton stepper. It accepts a stream of 20-cell ring states, compares each consecutive pair cell by cell, and reconstructs the 8-bit Wolfram rule number that produced the transitions. It tracks which rule bits have been witnessed and flags any transition that contradicts an earlier one. It sits downstream of the stepper or a state-capture port and feeds status and debug logic.

## Interface
- N, 20, ring width in cells (≥3); cell indexing and wrap are identical to the stepper's.
- PW, 8, width of the pair counter.

- clk  in  1  clock; all state changes on its rising edge.
- res  in  1  synchronous, active-high reset.
- st_valid  in  1  st_data/st_seq are valid.
- st_ready  out  1  block can accept a state this cycle.
- st_data  in  N  ring state; bit p is cell p.
- st_seq  in  1  qualifies a beat: this state starts a new sequence and is loaded as the predecessor only; no pair is formed.
- rul  out  8  inferred rule; bit k meaningful only where known[k]=1.
- known  out  8  bit k set once neighbourhood k has been observed.
- complete  out  1  &known.
- conflict  out  1  sticky contradiction flag.
- conflict_idx  out  3  neighbourhood index of the first contradiction.
- pairs  out  PW  transitions fully scanned, saturating at 2^PW−1.
- busy  out  1  scan in progress.

## Operation
- FSM states: EMPTY (no predecessor), IDLE (predecessor held), SCAN.
- A beat is accepted when st_valid & st_ready are both 1 at a clock edge.
- st_ready = 1 in EMPTY and IDLE; st_ready = 0 in SCAN.
- EMPTY, accepted beat: prev ← st_data; go to IDLE. st_seq is ignored.
- IDLE, accepted beat with st_seq=1: prev ← st_data; stay in IDLE. Table is untouched.
- IDLE, accepted beat with st_seq=0: curr ← st_data; pos ← 0; go to SCAN.
- SCAN, each cycle, for one pos:
  - Neighbourhood index: idx = {prev[pos+1], prev[pos], prev[pos−1]}, with indices taken modulo N. pos=0 uses prev[N−1]; pos=N−1 uses prev[0].
  - Observed value: obs = curr[pos].
  - If known[idx]=0: set known[idx] and write rul[idx] ← obs.
  - Else if rul[idx]≠obs: rul[idx] is not modified. If conflict was 0, set conflict=1 and conflict_idx ← idx.
  - Later conflicts never change conflict_idx.
- At pos=N−1, after the update: prev ← curr; pairs increments (saturating); go to IDLE.
- conflict and the table persist across st_seq; only res clears them.
- complete is combinational from the registered known.

## Timing
- Reset values: FSM=EMPTY, rul=0, known=0, conflict=0, conflict_idx=0, pairs=0, busy=0, st_ready=1. prev/curr are don't-care.
- res has priority over everything. res during SCAN aborts the scan with no partial pair counted; the next cycle is the reset state.
- Latency per pair:
  - Accept edge → busy=1 and st_ready=0 from the next cycle.
  - N SCAN cycles; known/rul update one cell per edge, visible the cycle after each edge.
  - After the N-th SCAN edge: busy=0, st_ready=1, pairs updated.
  - Sustained throughput: one pair per N+1 cycles.
- st_valid held high while st_ready=0 is not consumed. The held beat is accepted exactly once on the first cycle st_ready returns to 1.
- A single pair may both set and contradict the same idx; the first pos in scan order wins.

## Test plan
- Reset, then stream 0x00001 → 0x80000 → (after scan) known=0x17, rul&known=0x10, conflict=0, pairs=1, st_ready low for exactly 20 cycles.
- Full rule recovery:
  - Stimulus: stream 0x00003, 0x80002; then seq 0x55555, 0xAAAAA; then seq 0xFFFFF, 0xFFFFF.
  - Required: known=0xFF, rul=0xB8, complete=1, conflict=0, pairs=3.
- Conflict: reset, stream 0x00000 → 0x00001 → known=0x01, rul[0]=1, conflict=1, conflict_idx=0. A subsequent contradicting pair leaves conflict_idx=0.
- Backpressure: hold st_valid=1 with a new value throughout SCAN → that beat is accepted exactly once, on the first cycle after busy falls; pairs increments by 1 per pair, never 2.
- Reset mid-scan: assert res at SCAN pos=10 → next cycle all outputs at reset values, FSM=EMPTY; the first subsequent beat only loads prev (pairs stays 0).
- Saturation: with PW=2, stream 5 pairs of 0x00000 → pairs=3, known=0x01, rul=0x00.
